// File: rtl/nes_bus_pkg.sv
// Constants shared by the 2A03 CPU-bus glue (CPU, memory, PPU, OAM DMA):
// register addresses, bus cycle types and the OAM DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

  function automatic logic is_write_to(input logic [15:0] addr, input logic rw,
                                       input logic [15:0] target);
    return (rw == BUS_WRITE) && (addr == target);
  endfunction

  // DMA source address: the low byte never carries into the page.
  function automatic logic [15:0] dma_src_addr(input logic [7:0] page, input logic [7:0] count);
    return {page, count};
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU-bus view of the OAM DMA engine. The optional last_cycles status port
// exists only when OAM_DMA_CYCLE_COUNT_EN is defined.
interface oam_dma_if;

  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_rdata;

  logic        rdy;
  logic        dma_own;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_wdata;
  logic        dma_active;
`ifdef OAM_DMA_CYCLE_COUNT_EN
  logic [9:0]  last_cycles;
`endif

  modport master (
    input  cpu_addr, cpu_rw, cpu_wdata, bus_rdata,
`ifdef OAM_DMA_CYCLE_COUNT_EN
    output last_cycles,
`endif
    output rdy, dma_own, dma_addr, dma_rw, dma_wdata, dma_active
  );

  modport slave (
    output cpu_addr, cpu_rw, cpu_wdata, bus_rdata,
`ifdef OAM_DMA_CYCLE_COUNT_EN
    input  last_cycles,
`endif
    input  rdy, dma_own, dma_addr, dma_rw, dma_wdata, dma_active
  );

endinterface

// File: rtl/apu_cycle_parity.sv
// APU get/put toggle: parity is 0 in "get" cycles and 1 in "put" cycles,
// starting from 0 after reset. Shared by OAM DMA and the APU frame counter.
module apu_cycle_parity (
  input  logic clk,
  input  logic rst,
  output logic parity
);

  logic parity_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= ~parity_reg;
    end
  end

  assign parity = parity_reg;

endmodule

// File: rtl/oam_dma.sv
// 2A03 sprite DMA: a CPU write of page P to TRIGGER_ADDR halts the CPU and copies
// $PP00.. to the OAM port. Optional OAM_DMA_CYCLE_COUNT_EN adds the last_cycles status.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR  = ADDR_OAMDMA,
  parameter logic [15:0] OAM_PORT_ADDR = ADDR_OAMDATA,
  parameter int unsigned XFER_BYTES    = 256
) (
  input logic        clk,
  input logic        rst,
  oam_dma_if.master  bus
);

  localparam logic [7:0] LAST_COUNT = 8'(XFER_BYTES - 1);

  dma_state_t  state_reg;
  logic [7:0]  page_reg;
  logic [7:0]  count_reg;
  logic [7:0]  count_next;
  logic        parity;
  logic        trigger;
  logic        last_byte;

  logic        rdy_reg;
  logic        dma_own_reg;
  logic [15:0] dma_addr_reg;
  logic        dma_rw_reg;
  logic [7:0]  dma_wdata_reg;
  logic        dma_active_reg;

  apu_cycle_parity u_parity (
    .clk    (clk),
    .rst    (rst),
    .parity (parity)
  );

  assign trigger    = is_write_to(bus.cpu_addr, bus.cpu_rw, TRIGGER_ADDR);
  assign count_next = count_reg + 8'd1;
  assign last_byte  = (count_reg == LAST_COUNT);

  // Outputs are computed for the state being entered, so every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      page_reg       <= '0;
      count_reg      <= '0;
      rdy_reg        <= 1'b1;
      dma_own_reg    <= 1'b0;
      dma_addr_reg   <= '0;
      dma_rw_reg     <= BUS_READ;
      dma_wdata_reg  <= '0;
      dma_active_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (trigger) begin
            page_reg       <= bus.cpu_wdata;
            count_reg      <= '0;
            rdy_reg        <= 1'b0;
            dma_active_reg <= 1'b1;
            state_reg      <= ST_HALT;
          end
        end
        ST_HALT: begin
          // The CPU only stops on a read cycle; parity==1 now means a get cycle follows.
          if (bus.cpu_rw == BUS_READ) begin
            if (parity) begin
              dma_own_reg  <= 1'b1;
              dma_rw_reg   <= BUS_READ;
              dma_addr_reg <= dma_src_addr(page_reg, count_reg);
              state_reg    <= ST_READ;
            end else begin
              state_reg    <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          dma_own_reg  <= 1'b1;
          dma_rw_reg   <= BUS_READ;
          dma_addr_reg <= dma_src_addr(page_reg, count_reg);
          state_reg    <= ST_READ;
        end
        ST_READ: begin
          dma_wdata_reg <= bus.bus_rdata;
          dma_rw_reg    <= BUS_WRITE;
          dma_addr_reg  <= OAM_PORT_ADDR;
          state_reg     <= ST_WRITE;
        end
        ST_WRITE: begin
          if (last_byte) begin
            rdy_reg        <= 1'b1;
            dma_own_reg    <= 1'b0;
            dma_active_reg <= 1'b0;
            state_reg      <= ST_IDLE;
          end else begin
            count_reg    <= count_next;
            dma_rw_reg   <= BUS_READ;
            dma_addr_reg <= dma_src_addr(page_reg, count_next);
            state_reg    <= ST_READ;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rdy        = rdy_reg;
  assign bus.dma_own    = dma_own_reg;
  assign bus.dma_addr   = dma_addr_reg;
  assign bus.dma_rw     = dma_rw_reg;
  assign bus.dma_wdata  = dma_wdata_reg;
  assign bus.dma_active = dma_active_reg;

`ifdef OAM_DMA_CYCLE_COUNT_EN
  logic [9:0] cyc_cnt_reg;
  logic [9:0] last_cycles_reg;

  // The total is captured from the count before the final WRITE cycle is added.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_reg     <= '0;
      last_cycles_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      cyc_cnt_reg <= '0;
    end else begin
      cyc_cnt_reg <= cyc_cnt_reg + 10'd1;
      if (state_reg == ST_WRITE && last_byte) begin
        last_cycles_reg <= cyc_cnt_reg;
      end
    end
  end

  assign bus.last_cycles = last_cycles_reg;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Randomized self-checking bench for oam_dma: a 256-byte and a 4-byte instance share
// the CPU side and memory; expectations come from a cycle-level reference model.
`timescale 1ns/1ps
module tb_oam_dma;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAMP = 16'h2004;
  localparam logic [15:0] IDLE_ADDR = 16'h8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cpu_addr  = IDLE_ADDR;
  logic        cpu_rw    = 1'b1;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  mem [0:65535];

  oam_dma_if bus_a ();
  oam_dma_if bus_b ();

  assign bus_a.cpu_addr  = cpu_addr;
  assign bus_a.cpu_rw    = cpu_rw;
  assign bus_a.cpu_wdata = cpu_wdata;
  assign bus_a.bus_rdata = mem[bus_a.dma_own ? bus_a.dma_addr : cpu_addr];
  assign bus_b.cpu_addr  = cpu_addr;
  assign bus_b.cpu_rw    = cpu_rw;
  assign bus_b.cpu_wdata = cpu_wdata;
  assign bus_b.bus_rdata = mem[bus_b.dma_own ? bus_b.dma_addr : cpu_addr];

  oam_dma #(.XFER_BYTES(256)) dut (.clk(clk), .rst(rst), .bus(bus_a));
  oam_dma #(.XFER_BYTES(4))   dut_short (.clk(clk), .rst(rst), .bus(bus_b));

  // Bus cycle number since reset release; even numbers are get cycles.
  int unsigned edge_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-instance observations of one transfer.
  logic [15:0] rd_addr [2][256];
  logic [7:0]  wr_data [2][256];
  int n_rd [2];
  int n_wr [2];
  int rdy_low [2];
  int act_cnt [2];
  int bad_wr [2];
  int first_low [2];
  int xfer_len [2] = '{256, 4};

  task automatic sample_dut(input int d, input logic rdy, input logic own, input logic rw,
                            input logic act, input logic [15:0] addr, input logic [7:0] wd);
    if (!rdy) begin
      if (first_low[d] < 0) first_low[d] = int'(edge_cnt);
      rdy_low[d]++;
    end
    if (act) act_cnt[d]++;
    if (own && rw) begin
      if (n_rd[d] < 256) rd_addr[d][n_rd[d]] = addr;
      n_rd[d]++;
    end
    if (own && !rw) begin
      if (n_wr[d] < 256) wr_data[d][n_wr[d]] = wd;
      if (addr != OAMP) bad_wr[d]++;
      n_wr[d]++;
    end
  endtask

  task automatic cpu_cycle(input logic [15:0] addr, input logic rw, input logic [7:0] wd);
    cpu_addr = addr; cpu_rw = rw; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_addr = IDLE_ADDR; cpu_rw = 1'b1; cpu_wdata = 8'h00;
  endtask

  task automatic check_idle(input string tag);
    check_value({tag, "_rdy"}, bus_a.rdy, 1'b1);
    check_value({tag, "_own"}, bus_a.dma_own, 1'b0);
    check_value({tag, "_active"}, bus_a.dma_active, 1'b0);
  endtask

  // trig_even: trigger cycle number is even (parity becomes 1 on the trigger edge).
  task automatic run_xfer(input logic [7:0] page, input bit trig_even, input int extra,
                          input int abort_after);
    int k, h, first_read, rdy_exp, n, extra_left;
    bit done, aborted;
    logic [15:0] src;
    if (((edge_cnt % 2) == 0) != trig_even) cpu_cycle(IDLE_ADDR, 1'b1, 8'h00);
    for (int d = 0; d < 2; d++) begin
      n_rd[d] = 0; n_wr[d] = 0; rdy_low[d] = 0; act_cnt[d] = 0; bad_wr[d] = 0; first_low[d] = -1;
    end
    k = int'(edge_cnt);
    cpu_addr = TRIG; cpu_rw = 1'b0; cpu_wdata = page;
    extra_left = extra; done = 1'b0; aborted = 1'b0;
    for (int c = 0; c < 700 && !done; c++) begin
      @(negedge clk);
      sample_dut(0, bus_a.rdy, bus_a.dma_own, bus_a.dma_rw, bus_a.dma_active, bus_a.dma_addr, bus_a.dma_wdata);
      sample_dut(1, bus_b.rdy, bus_b.dma_own, bus_b.dma_rw, bus_b.dma_active, bus_b.dma_addr, bus_b.dma_wdata);
      @(posedge clk); #1;
      if (extra_left > 0) extra_left--;
      else begin cpu_addr = IDLE_ADDR; cpu_rw = 1'b1; cpu_wdata = 8'h00; end
      if (abort_after >= 0 && n_wr[0] == abort_after) begin
        aborted = 1'b1; done = 1'b1;
      end else if (!bus_a.dma_active && !bus_b.dma_active) begin
        done = 1'b1;
      end
    end
    check_value("xfer_terminates", done, 1'b1);
    $display("xfer page=%02h trig_cycle=%0d extra=%0d rdy_low=%0d/%0d writes=%0d/%0d%s",
             page, k, extra, rdy_low[0], rdy_low[1], n_wr[0], n_wr[1], aborted ? " (reset abort)" : "");
    if (aborted) begin
      rst = 1'b1; #1;
      check_idle("abort_now");
`ifdef OAM_DMA_CYCLE_COUNT_EN
      check_value("abort_last_cycles", bus_a.last_cycles, 10'd0);
`endif
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check_value("abort_no_trailing_own", bus_a.dma_own, 1'b0);
        check_value("abort_active", bus_a.dma_active, 1'b0);
      end
      check_value("abort_writes", n_wr[0], abort_after);
      @(posedge clk); #1;
      return;
    end
    // Reference: HALT lasts 1+extra cycles; READ/WRITE pairs start on the next even cycle.
    h = 1 + extra;
    first_read = k + h + 1 + ((k + h + 1) % 2);
    for (int d = 0; d < 2; d++) begin
      n = xfer_len[d];
      rdy_exp = first_read - (k + 1) + 2 * n;
      check_value($sformatf("rdy_low_cycles[%0d]", d), rdy_low[d], rdy_exp);
      check_value($sformatf("active_cycles[%0d]", d), act_cnt[d], rdy_exp);
      check_value($sformatf("rdy_fall_cycle[%0d]", d), first_low[d], k + 1);
      check_value($sformatf("n_reads[%0d]", d), n_rd[d], n);
      check_value($sformatf("n_writes[%0d]", d), n_wr[d], n);
      check_value($sformatf("bad_wr_addr[%0d]", d), bad_wr[d], 0);
      for (int i = 0; i < n && i < n_rd[d] && i < n_wr[d]; i++) begin
        src = {page, 8'(i)};
        check_value($sformatf("rd_addr[%0d][%0d]", d, i), rd_addr[d][i], src);
        check_value($sformatf("wr_data[%0d][%0d]", d, i), wr_data[d][i], mem[src]);
      end
`ifdef OAM_DMA_CYCLE_COUNT_EN
      check_value($sformatf("last_cycles[%0d]", d), d == 0 ? bus_a.last_cycles : bus_b.last_cycles,
                  rdy_exp - 1);
`endif
    end
    check_idle("after_xfer");
    check_value("after_xfer_short_rdy", bus_b.rdy, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check_value("reset_dma_addr", bus_a.dma_addr, 16'h0000);
    check_value("reset_dma_rw", bus_a.dma_rw, 1'b1);
    check_value("reset_dma_wdata", bus_a.dma_wdata, 8'h00);
`ifdef OAM_DMA_CYCLE_COUNT_EN
    check_value("reset_last_cycles", bus_a.last_cycles, 10'd0);
`endif
    rst = 1'b0;

    run_xfer(8'h02, 1'b1, 0, -1);
    run_xfer(8'h02, 1'b0, 0, -1);
    run_xfer(8'hFF, 1'($urandom_range(0, 1)), 0, -1);
    run_xfer(8'h02, 1'b1, 0, 10);
    run_xfer(8'h03, 1'($urandom_range(0, 1)), 0, -1);

    cpu_cycle(TRIG, 1'b1, 8'h02);
    check_idle("read_trigger_addr");
    cpu_cycle(16'h4015, 1'b0, 8'h02);
    check_idle("write_4015");
    run_xfer(8'h80, 1'($urandom_range(0, 1)), 2, -1);

    rst = 1'b1;
    cpu_addr = TRIG; cpu_rw = 1'b0; cpu_wdata = 8'h05;
    @(posedge clk); #1;
    cpu_addr = IDLE_ADDR; cpu_rw = 1'b1; cpu_wdata = 8'h00;
    rst = 1'b0; #1;
    check_idle("reset_wins_trigger");
    @(posedge clk); #1;
    check_value("reset_wins_active_later", bus_a.dma_active, 1'b0);

    for (int t = 0; t < 3; t++) begin
      run_xfer(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
